// File: rtl/mem_port_arbiter.sv
// Round-robin owner of the single main-memory port, shared by I-cache refill (0) and D-cache refill/write-back (1).
// Sequences one BLOCK_WORDS-beat burst per grant and steers requester address/data through SEL.
module mem_port_arbiter #(
    parameter int BLOCK_WORDS = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req0,
    input  logic [ADDR_WIDTH-1:0]          addr0,
    input  logic                           we0,
    input  logic [DATA_WIDTH-1:0]          wdata0,
    input  logic                           req1,
    input  logic [ADDR_WIDTH-1:0]          addr1,
    input  logic                           we1,
    input  logic [DATA_WIDTH-1:0]          wdata1,
    input  logic                           mem_ready,
    input  logic [DATA_WIDTH-1:0]          mem_rdata,
    output logic                           mem_req,
    output logic                           mem_we,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    output logic [DATA_WIDTH-1:0]          mem_wdata,
    output logic                           sel,
    output logic                           gnt0,
    output logic                           gnt1,
    output logic [$clog2(BLOCK_WORDS)-1:0] beat_idx,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic                           valid0,
    output logic                           valid1,
    output logic                           done0,
    output logic                           done1
);

    localparam int BEAT_W = $clog2(BLOCK_WORDS);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(BLOCK_WORDS * 4 - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                  state, state_d;
    logic [ADDR_WIDTH-1:0]   base, base_d;
    logic                    last_served, last_served_d;
    logic                    sel_d, gnt0_d, gnt1_d, mem_req_d, mem_we_d;
    logic [BEAT_W-1:0]       beat_d;
    logic                    winner;
    logic                    last_beat;

    assign last_beat = (beat_idx == BEAT_W'(BLOCK_WORDS - 1));

    // NOTE: every next-state signal gets its hold value first, so no branch can infer a latch.
    always_comb begin
        state_d       = state;
        base_d        = base;
        last_served_d = last_served;
        sel_d         = sel;
        gnt0_d        = gnt0;
        gnt1_d        = gnt1;
        mem_req_d     = mem_req;
        mem_we_d      = mem_we;
        beat_d        = beat_idx;
        // On a tie the requester that was not served last wins.
        winner        = (req0 && req1) ? ~last_served : req1;

        unique case (state)
            IDLE: begin
                if (req0 || req1) begin
                    state_d   = BUSY;
                    sel_d     = winner;
                    gnt0_d    = ~winner;
                    gnt1_d    = winner;
                    mem_req_d = 1'b1;
                    mem_we_d  = winner ? we1 : we0;
                    base_d    = (winner ? addr1 : addr0) & ~OFF_MASK;
                    beat_d    = '0;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    if (last_beat) begin
                        state_d       = IDLE;
                        gnt0_d        = 1'b0;
                        gnt1_d        = 1'b0;
                        mem_req_d     = 1'b0;
                        mem_we_d      = 1'b0;
                        beat_d        = '0;
                        last_served_d = sel;
                    end else begin
                        beat_d = beat_idx + BEAT_W'(1);
                    end
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            base        <= '0;
            last_served <= 1'b1;
            sel         <= 1'b0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            beat_idx    <= '0;
        end else begin
            state       <= state_d;
            base        <= base_d;
            last_served <= last_served_d;
            sel         <= sel_d;
            gnt0        <= gnt0_d;
            gnt1        <= gnt1_d;
            mem_req     <= mem_req_d;
            mem_we      <= mem_we_d;
            beat_idx    <= beat_d;
        end
    end

    // Burst address wraps naturally at the ADDR_WIDTH boundary.
    assign mem_addr  = base + (ADDR_WIDTH'(beat_idx) << 2);
    assign mem_wdata = sel ? wdata1 : wdata0;
    assign rdata     = mem_rdata;

    assign valid0 = gnt0 & mem_ready & ~mem_we;
    assign valid1 = gnt1 & mem_ready & ~mem_we;
    assign done0  = gnt0 & mem_ready & last_beat;
    assign done1  = gnt1 & mem_ready & last_beat;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus queues expected beats, a negedge monitor
// pops and compares one record per accepted memory beat.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst, req0, we0, req1, we1, mem_ready;
    logic [31:0] addr0, wdata0, addr1, wdata1, mem_rdata;
    logic        mem_req, mem_we, sel, gnt0, gnt1;
    logic [31:0] mem_addr, mem_wdata, rdata;
    logic [1:0]  beat_idx;
    logic        valid0, valid1, done0, done1;

    mem_port_arbiter #(.BLOCK_WORDS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .we0(we0), .wdata0(wdata0),
        .req1(req1), .addr1(addr1), .we1(we1), .wdata1(wdata1),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .sel(sel), .gnt0(gnt0), .gnt1(gnt1), .beat_idx(beat_idx), .rdata(rdata),
        .valid0(valid0), .valid1(valid1), .done0(done0), .done1(done1)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        owner;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;
    int    total = 0;
    int    bad = 0;
    int    valid1_cnt = 0;
    logic  track_wdata = 1'b0;

    logic pat[7]      = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    int   pat_beat[7] = '{0, 1, 1, 1, 2, 3, 3};
    logic pat_done[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check(name, {31'b0, act}, {31'b0, exp});
    endtask

    task automatic push_beat(input logic owner, input logic [31:0] addr, input logic we,
                             input logic [31:0] wdata, input logic last);
        beat_t b;
        b.owner = owner; b.addr = addr; b.we = we; b.wdata = wdata; b.last = last;
        exp_q.push_back(b);
    endtask

    task automatic push_block(input logic owner, input logic [31:0] base, input logic we,
                              input logic [31:0] wbase);
        for (int i = 0; i < 4; i++)
            push_beat(owner, base + 32'(4 * i), we, wbase + 32'(i), i == 3);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (track_wdata) wdata1 = 32'h0A0 + 32'(beat_idx);
        mem_rdata = mem_rdata + 32'h0101_0101;
    endtask

    // Runs until the owner's DONE is seen (bounded), then steps into the following IDLE cycle.
    task automatic wait_done(input logic which, output int n);
        n = 0;
        while ((which ? done1 : done0) !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check1("done_seen", which ? done1 : done0, 1'b1);
        step();
    endtask

    always @(negedge clk) begin
        if (mem_req === 1'b1 && mem_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got addr %h expected no beat", mem_addr);
            end else begin
                mon_e = exp_q.pop_front();
                check1("mon_sel", sel, mon_e.owner);
                check1("mon_gnt0", gnt0, ~mon_e.owner);
                check1("mon_gnt1", gnt1, mon_e.owner);
                check("mon_addr", mem_addr, mon_e.addr);
                check1("mon_we", mem_we, mon_e.we);
                check1("mon_valid0", valid0, ~mon_e.owner & ~mon_e.we);
                check1("mon_valid1", valid1, mon_e.owner & ~mon_e.we);
                check1("mon_done0", done0, ~mon_e.owner & mon_e.last);
                check1("mon_done1", done1, mon_e.owner & mon_e.last);
                if (mon_e.we) check("mon_wdata", mem_wdata, mon_e.wdata);
                else          check("mon_rdata", rdata, mem_rdata);
            end
        end else if (mem_ready === 1'b1) begin
            check("idle_quiet", {28'b0, valid0, valid1, done0, done1}, 32'h0);
        end
        if (valid1 === 1'b1) valid1_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int v1;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0; mem_ready = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; mem_rdata = 32'h1357_9BDF;
        step();
        step();
        rst = 1'b0;
        check1("rst_mem_req", mem_req, 1'b0);
        check1("rst_gnt0", gnt0, 1'b0);
        check1("rst_gnt1", gnt1, 1'b0);
        check1("rst_sel", sel, 1'b0);
        check1("rst_mem_we", mem_we, 1'b0);
        check("rst_beat", 32'(beat_idx), 32'd0);
        check("rst_addr", mem_addr, 32'h0);

        // Single read burst
        req0 = 1'b1; addr0 = 32'h0000_1234; we0 = 1'b0; mem_ready = 1'b1;
        push_beat(1'b0, 32'h0000_1230, 1'b0, 32'h0, 1'b0);
        push_beat(1'b0, 32'h0000_1234, 1'b0, 32'h0, 1'b0);
        push_beat(1'b0, 32'h0000_1238, 1'b0, 32'h0, 1'b0);
        push_beat(1'b0, 32'h0000_123C, 1'b0, 32'h0, 1'b1);
        step();
        check1("t1_gnt0", gnt0, 1'b1);
        check1("t1_mem_req", mem_req, 1'b1);
        check("t1_addr0", mem_addr, 32'h0000_1230);
        wait_done(1'b0, n);
        check("t1_done_cycle", n, 3);
        check1("t1_idle_req", mem_req, 1'b0);
        check1("t1_idle_gnt0", gnt0, 1'b0);
        req0 = 1'b0;

        // Tie from reset: requester 0 first, then 1, then 0 again
        rst = 1'b1;
        step();
        rst = 1'b0;
        req0 = 1'b1; req1 = 1'b1; addr0 = 32'h0000_2000; addr1 = 32'h0000_3008;
        push_block(1'b0, 32'h0000_2000, 1'b0, 32'h0);
        push_block(1'b1, 32'h0000_3000, 1'b0, 32'h0);
        step();
        check1("t2_gnt0", gnt0, 1'b1);
        check1("t2_gnt1", gnt1, 1'b0);
        wait_done(1'b0, n);
        req0 = 1'b0;
        check1("t2_idle_sel", sel, 1'b0);
        check1("t2_idle_gnt1", gnt1, 1'b0);
        step();
        check1("t2_second_gnt1", gnt1, 1'b1);
        check1("t2_second_sel", sel, 1'b1);
        wait_done(1'b1, n);
        check1("t2_idle_sel_hold", sel, 1'b1);
        req0 = 1'b1; req1 = 1'b1; addr0 = 32'h0000_4010; addr1 = 32'h0000_500C;
        push_block(1'b0, 32'h0000_4010, 1'b0, 32'h0);
        push_block(1'b1, 32'h0000_5000, 1'b0, 32'h0);
        step();
        check1("t2_rr_gnt0", gnt0, 1'b1);
        wait_done(1'b0, n);
        req0 = 1'b0;
        step();
        check1("t2_rr_gnt1", gnt1, 1'b1);
        wait_done(1'b1, n);
        req1 = 1'b0;

        // Stalled read for requester 1
        v1 = valid1_cnt;
        req1 = 1'b1; addr1 = 32'h0000_0104; we1 = 1'b0; mem_ready = 1'b0;
        push_block(1'b1, 32'h0000_0100, 1'b0, 32'h0);
        step();
        for (int i = 0; i < 7; i++) begin
            mem_ready = pat[i];
            #1;
            check("t3_beat", 32'(beat_idx), 32'(pat_beat[i]));
            check("t3_addr", mem_addr, 32'h0000_0100 + 32'(4 * pat_beat[i]));
            check1("t3_done1", done1, pat_done[i]);
            step();
        end
        req1 = 1'b0; mem_ready = 1'b0;
        check1("t3_idle_req", mem_req, 1'b0);
        check("t3_valid_count", valid1_cnt - v1, 4);

        // Write-back from requester 1
        v1 = valid1_cnt;
        req1 = 1'b1; addr1 = 32'h0000_0200; we1 = 1'b1; mem_ready = 1'b1; track_wdata = 1'b1;
        push_block(1'b1, 32'h0000_0200, 1'b1, 32'h0000_00A0);
        step();
        check1("t4_mem_we", mem_we, 1'b1);
        wait_done(1'b1, n);
        req1 = 1'b0; we1 = 1'b0; track_wdata = 1'b0;
        check("t4_no_valid", valid1_cnt - v1, 0);

        // Request dropped and address/we changed mid-burst, then ready pulses while idle
        req0 = 1'b1; addr0 = 32'h0000_0F3C; we0 = 1'b0;
        push_block(1'b0, 32'h0000_0F30, 1'b0, 32'h0);
        step();
        step();
        req0 = 1'b0; addr0 = 32'h0000_9990; we0 = 1'b1;
        wait_done(1'b0, n);
        check("t5_beats_left", n, 2);
        for (int i = 0; i < 3; i++) begin
            check1("t5_idle_req", mem_req, 1'b0);
            step();
        end
        we0 = 1'b0;

        // Reset during beat 2, then a fresh request
        req0 = 1'b1; addr0 = 32'h0000_0700;
        push_block(1'b0, 32'h0000_0700, 1'b0, 32'h0);
        step();
        step();
        step();
        check("t6_beat_before", 32'(beat_idx), 32'd2);
        rst = 1'b1;
        step();
        check1("t6_mem_req", mem_req, 1'b0);
        check1("t6_gnt0", gnt0, 1'b0);
        check("t6_beat", 32'(beat_idx), 32'd0);
        check1("t6_done0", done0, 1'b0);
        check("t6_abandoned", 32'(exp_q.size()), 32'd1);
        exp_q.delete();
        rst = 1'b0; addr0 = 32'h0000_0800;
        push_block(1'b0, 32'h0000_0800, 1'b0, 32'h0);
        step();
        check1("t6_regrant", gnt0, 1'b1);
        check("t6_regrant_addr", mem_addr, 32'h0000_0800);
        wait_done(1'b0, n);
        req0 = 1'b0; mem_ready = 1'b0;
        step();

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single main-memory port between the I-cache refill path (requester 0) and the D-cache refill/write-back path (requester 1).
- Arbitrates round-robin at block granularity and sequences a BLOCK_WORDS-beat transfer with an internal beat counter and address increment.
- Drives SEL for the 32-bit 2:1 datapath muxes that steer requester address/data onto the memory port.

Parameters:
BLOCK_WORDS  4   words per cache-block transfer; power of two, >=2
ADDR_WIDTH   32  byte-address width
DATA_WIDTH   32  data word width

Ports:
CLK        input   1           clock; everything sampled on rising edge
RST        input   1           synchronous reset, active-high
REQ0       input   1           requester 0 block request; held until DONE0
ADDR0      input   ADDR_WIDTH  requester 0 block address
WE0        input   1           requester 0 write (1) / read (0)
WDATA0     input   DATA_WIDTH  requester 0 write data for current BEAT_IDX
REQ1       input   1           requester 1 block request
ADDR1      input   ADDR_WIDTH  requester 1 block address
WE1        input   1           requester 1 write/read
WDATA1     input   DATA_WIDTH  requester 1 write data for current BEAT_IDX
MEM_READY  input   1           memory beat accepted/completed this cycle
MEM_RDATA  input   DATA_WIDTH  memory read data, valid with MEM_READY
MEM_REQ    output  1           transfer active on memory port
MEM_WE     output  1           latched WE of owner
MEM_ADDR   output  ADDR_WIDTH  base + 4*BEAT_IDX
MEM_WDATA  output  DATA_WIDTH  owner's WDATA via SEL
SEL        output  1           0 = requester 0 owns port, 1 = requester 1
GNT0       output  1           requester 0 owns port
GNT1       output  1           requester 1 owns port
BEAT_IDX   output  clog2(BLOCK_WORDS)  current beat number
RDATA      output  DATA_WIDTH  MEM_RDATA passthrough
VALID0     output  1           read beat valid for requester 0
VALID1     output  1           read beat valid for requester 1
DONE0      output  1           last beat of requester 0 transfer
DONE1      output  1           last beat of requester 1 transfer

Behaviour:
- Clock and reset: single clock CLK. RST is synchronous and active-high.
- Reset values: state IDLE; MEM_REQ, GNT0, GNT1, SEL, MEM_WE = 0; BEAT_IDX = 0; base = 0; last-served pointer = 1, so requester 0 wins the first tie.
- State machine, two states:
  - IDLE: if any REQ is high, register the winner, latch base = ADDRx with low log2(BLOCK_WORDS*4) bits cleared, latch WEx, clear BEAT_IDX, go to BUSY.
  - BUSY: on every cycle with MEM_READY=1, increment BEAT_IDX. On the last beat (BEAT_IDX == BLOCK_WORDS-1 and MEM_READY=1), update last-served = owner, clear BEAT_IDX, go to IDLE.
- Arbitration:
  - Only one REQ high: that requester wins.
  - Both high: the requester not last served wins.
  - Decision happens only in IDLE. No preemption.
- Latency: REQ sampled high in IDLE at cycle t gives GNTx=1, MEM_REQ=1 and MEM_ADDR=base from t+1.
- Registered and combinational outputs:
  - GNT0/GNT1/SEL/MEM_REQ/MEM_WE are registered and change only on state transitions. SEL keeps the last owner while IDLE.
  - MEM_ADDR, MEM_WDATA and RDATA are combinational.
  - VALIDx = GNTx & MEM_READY & ~MEM_WE.
  - DONEx = GNTx & MEM_READY & last beat, a one-cycle pulse in the final BUSY cycle.
- Handshake:
  - A requester deasserts REQ in the cycle after DONE.
  - Any REQ seen high in IDLE is a new request.
  - At least one IDLE cycle separates consecutive grants.
- Boundary conditions:
  - REQ drops mid-transfer: ignored; the transfer completes all beats.
  - ADDRx/WEx change mid-transfer: ignored, since they are latched. WDATAx is not latched and must track BEAT_IDX.
  - MEM_READY in IDLE: ignored; no VALID or DONE is produced.
  - MEM_READY low stalls: BEAT_IDX and MEM_ADDR hold.
  - Address increment wraps modulo ADDR_WIDTH.
  - RST in BUSY: aborts the transfer next edge with reset values; no DONE is emitted.

Test Plan:
- Single read, BLOCK_WORDS=4: REQ0=1, ADDR0=0x0000_1234, WE0=0, MEM_READY held 1 -> GNT0 at t+1; MEM_ADDR 0x1230, 0x1234, 0x1238, 0x123C; VALID0 on 4 cycles; DONE0 at t+4; IDLE at t+5.
- Tie round-robin: REQ0 and REQ1 high from reset -> requester 0 served first; after DONE0 and one IDLE cycle, GNT1=1 and SEL=1; a repeated tie next goes to requester 0.
- Stalls: MEM_READY pattern 1,0,0,1,1,0,1 -> BEAT_IDX/MEM_ADDR hold on 0 cycles; exactly 4 VALID1 pulses; DONE1 coincides with the 4th ready.
- Write-back: REQ1 with WE1=1 and WDATA1=0xA0+BEAT_IDX -> MEM_WE=1; MEM_WDATA = 0xA0, 0xA1, 0xA2, 0xA3; VALID1 never asserted; DONE1 asserted.
- Disturbance: REQ0 dropped after beat 1 and ADDR0 changed -> transfer completes 4 beats at the original addresses; MEM_READY pulses while IDLE -> no VALID/DONE.
- Reset mid-transfer: RST=1 at beat 2 -> next edge MEM_REQ=0, GNT0=0, BEAT_IDX=0, no DONE0; a new REQ after reset is granted normally.
